// File: rtl/filter_pkg.sv
// Shared types, widths and helpers for the 3x3 filter core.
// The kernel ALU and the pipeline top both import this package.
package filter_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SUM_W  = 12;
  localparam int unsigned GRAD_W = 11;
  localparam int unsigned RAW_W  = GRAD_W + 1;

  typedef enum logic [1:0] {
    FMODE_PASS    = 2'd0,
    FMODE_GAUSS   = 2'd1,
    FMODE_SOBEL   = 2'd2,
    FMODE_LAPLACE = 2'd3
  } fmode_t;

  // 3x3 window, field pRC = row R, column C; p11 is the centre
  typedef struct packed {
    logic [PIX_W-1:0] p00, p01, p02;
    logic [PIX_W-1:0] p10, p11, p12;
    logic [PIX_W-1:0] p20, p21, p22;
  } win_t;

  // Two's-complement raw result -> 0..255
  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [RAW_W-1:0] raw);
    logic [PIX_W-1:0] res;
    if (raw[RAW_W-1])
      res = '0;
    else if (|raw[RAW_W-2:PIX_W])
      res = '1;
    else
      res = raw[PIX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/filter_kernel_alu.sv
// Combinational 3x3 kernel arithmetic: window + mode -> unclamped two's-complement result.
// Sits between pipeline stages S1 and S2 of filter_core_3x3.
module filter_kernel_alu
  import filter_pkg::*;
(
  input  win_t             win_i,
  input  fmode_t           mode_i,
  output logic [RAW_W-1:0] raw_o
);

  logic [SUM_W-1:0]  gsum;
  logic [GRAD_W-1:0] gx;
  logic [GRAD_W-1:0] gy;
  logic [RAW_W-1:0]  gx_ext;
  logic [RAW_W-1:0]  gy_ext;
  logic [RAW_W-1:0]  gx_abs;
  logic [RAW_W-1:0]  gy_abs;
  logic [RAW_W-1:0]  lap;

  always_comb begin
    gsum = SUM_W'(win_i.p00) + SUM_W'(win_i.p02) + SUM_W'(win_i.p20) + SUM_W'(win_i.p22)
         + ((SUM_W'(win_i.p01) + SUM_W'(win_i.p10) + SUM_W'(win_i.p12) + SUM_W'(win_i.p21)) << 1)
         + (SUM_W'(win_i.p11) << 2);

    // Gradients wrap modulo 2^GRAD_W; the true range -1020..1020 always fits
    gx = (GRAD_W'(win_i.p02) + (GRAD_W'(win_i.p12) << 1) + GRAD_W'(win_i.p22))
       - (GRAD_W'(win_i.p00) + (GRAD_W'(win_i.p10) << 1) + GRAD_W'(win_i.p20));
    gy = (GRAD_W'(win_i.p20) + (GRAD_W'(win_i.p21) << 1) + GRAD_W'(win_i.p22))
       - (GRAD_W'(win_i.p00) + (GRAD_W'(win_i.p01) << 1) + GRAD_W'(win_i.p02));
    gx_ext = {gx[GRAD_W-1], gx};
    gy_ext = {gy[GRAD_W-1], gy};
    gx_abs = gx_ext[RAW_W-1] ? -gx_ext : gx_ext;
    gy_abs = gy_ext[RAW_W-1] ? -gy_ext : gy_ext;

    lap = (RAW_W'(win_i.p11) << 2)
        - (RAW_W'(win_i.p01) + RAW_W'(win_i.p10) + RAW_W'(win_i.p12) + RAW_W'(win_i.p21));

    raw_o = RAW_W'(win_i.p11);
    case (mode_i)
      FMODE_PASS:    raw_o = RAW_W'(win_i.p11);
      FMODE_GAUSS:   raw_o = RAW_W'((gsum + SUM_W'(8)) >> 4);
      FMODE_SOBEL:   raw_o = gx_abs + gy_abs;
      FMODE_LAPLACE: raw_o = lap;
      default:       raw_o = RAW_W'(win_i.p11);
    endcase
  end

endmodule

// File: rtl/filter_core_3x3.sv
// Three-stage 3x3 filter pipeline: S1 window/mode capture, S2 raw kernel result,
// S3 clamp plus output position counters and line/frame done pulses.
module filter_core_3x3
  import filter_pkg::*;
#(
  parameter int unsigned IMG_COLS = 540,
  parameter int unsigned IMG_ROWS = 960,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned ROW_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_en_i,
  input  logic [PIX_W-1:0] data_0_0_i,
  input  logic [PIX_W-1:0] data_0_1_i,
  input  logic [PIX_W-1:0] data_0_2_i,
  input  logic [PIX_W-1:0] data_1_0_i,
  input  logic [PIX_W-1:0] data_1_1_i,
  input  logic [PIX_W-1:0] data_1_2_i,
  input  logic [PIX_W-1:0] data_2_0_i,
  input  logic [PIX_W-1:0] data_2_1_i,
  input  logic [PIX_W-1:0] data_2_2_i,
  input  logic [1:0]       mode_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             pix_valid_o,
  output logic [COL_W-1:0] pix_col_o,
  output logic [ROW_W-1:0] pix_row_o,
  output logic             line_done_o,
  output logic             frame_done_o,
  output logic             busy_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);

  win_t             win_c;
  fmode_t           mode_sel_c;
  logic [RAW_W-1:0] raw_c;
  logic             line_last_c;

  logic             s1_valid_q, s1_valid_d;
  win_t             s1_win_q, s1_win_d;
  fmode_t           s1_mode_q, s1_mode_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  fmode_t           line_mode_q, line_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [RAW_W-1:0] s2_raw_q, s2_raw_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             pix_valid_q, pix_valid_d;
  logic [COL_W-1:0] pix_col_q, pix_col_d;
  logic [ROW_W-1:0] pix_row_q, pix_row_d;
  logic             line_done_q, line_done_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;

  assign win_c = {data_0_0_i, data_0_1_i, data_0_2_i,
                  data_1_0_i, data_1_1_i, data_1_2_i,
                  data_2_0_i, data_2_1_i, data_2_2_i};

  // Mode is taken from the port only on the first window of a line, then held
  assign mode_sel_c  = (in_col_q == '0) ? fmode_t'(mode_i) : line_mode_q;
  assign line_last_c = (out_col_q == LAST_COL);

  filter_kernel_alu u_alu (
    .win_i  (s1_win_q),
    .mode_i (s1_mode_q),
    .raw_o  (raw_c)
  );

  always_comb begin
    s1_valid_d   = core_en_i;
    s1_win_d     = s1_win_q;
    s1_mode_d    = s1_mode_q;
    in_col_d     = in_col_q;
    line_mode_d  = line_mode_q;
    s2_valid_d   = s1_valid_q;
    s2_raw_d     = s2_raw_q;
    pix_d        = pix_q;
    pix_valid_d  = s2_valid_q;
    pix_col_d    = pix_col_q;
    pix_row_d    = pix_row_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    // Registered equivalent of OR(S1,S2,S3 valid) as seen after this edge
    busy_d       = core_en_i | s1_valid_q | s2_valid_q;

    if (core_en_i) begin
      s1_win_d  = win_c;
      s1_mode_d = mode_sel_c;
      if (in_col_q == '0)
        line_mode_d = fmode_t'(mode_i);
      in_col_d = (in_col_q == LAST_COL) ? '0 : in_col_q + COL_W'(1);
    end

    if (s1_valid_q)
      s2_raw_d = raw_c;

    if (s2_valid_q) begin
      pix_d        = clamp_pix(s2_raw_q);
      pix_col_d    = out_col_q;
      pix_row_d    = out_row_q;
      line_done_d  = line_last_c;
      frame_done_d = line_last_c && (out_row_q == LAST_ROW);
      out_col_d    = line_last_c ? '0 : out_col_q + COL_W'(1);
      if (line_last_c)
        out_row_d = (out_row_q == LAST_ROW) ? '0 : out_row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_win_q     <= '0;
      s1_mode_q    <= FMODE_PASS;
      in_col_q     <= '0;
      line_mode_q  <= FMODE_PASS;
      s2_valid_q   <= 1'b0;
      s2_raw_q     <= '0;
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_col_q    <= '0;
      pix_row_q    <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_win_q     <= s1_win_d;
      s1_mode_q    <= s1_mode_d;
      in_col_q     <= in_col_d;
      line_mode_q  <= line_mode_d;
      s2_valid_q   <= s2_valid_d;
      s2_raw_q     <= s2_raw_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      pix_col_q    <= pix_col_d;
      pix_row_q    <= pix_row_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
    end
  end

  assign pix_o        = pix_q;
  assign pix_valid_o  = pix_valid_q;
  assign pix_col_o    = pix_col_q;
  assign pix_row_o    = pix_row_q;
  assign line_done_o  = line_done_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_filter_core_3x3.sv
// Directed bench for filter_core_3x3 on a 4x2 image: vector table of kernel cases
// plus hand-written sequences for latency, gaps, mode latch and mid-line reset.
module tb_filter_core_3x3;
  import filter_pkg::*;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 2;
  localparam int unsigned CW   = 2;
  localparam int unsigned RW   = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            core_en;
  logic [1:0]      mode_in;
  logic [8:0][7:0] win;
  logic [7:0]      pix_o;
  logic            pix_valid_o;
  logic [CW-1:0]   pix_col_o;
  logic [RW-1:0]   pix_row_o;
  logic            line_done_o;
  logic            frame_done_o;
  logic            busy_o;

  always #5 clk = ~clk;

  filter_core_3x3 #(
    .IMG_COLS (COLS),
    .IMG_ROWS (ROWS),
    .COL_W    (CW),
    .ROW_W    (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_en_i    (core_en),
    .data_0_0_i   (win[0]),
    .data_0_1_i   (win[1]),
    .data_0_2_i   (win[2]),
    .data_1_0_i   (win[3]),
    .data_1_1_i   (win[4]),
    .data_1_2_i   (win[5]),
    .data_2_0_i   (win[6]),
    .data_2_1_i   (win[7]),
    .data_2_2_i   (win[8]),
    .mode_i       (mode_in),
    .pix_o        (pix_o),
    .pix_valid_o  (pix_valid_o),
    .pix_col_o    (pix_col_o),
    .pix_row_o    (pix_row_o),
    .line_done_o  (line_done_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [1:0]      mode;
    logic [8:0][7:0] w;
    logic [7:0]      exp;
  } vec_t;

  typedef struct packed {
    logic       en;
    logic [7:0] pix;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_col  = 0;
  int unsigned exp_row  = 0;
  logic [7:0]  last_pix = '0;
  exp_t        hist [3];
  vec_t        vecs [13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0][7:0] mk(input logic [7:0] c, input logic [7:0] n);
    logic [8:0][7:0] r;
    for (int i = 0; i < 9; i++) r[i] = n;
    r[4] = c;
    return r;
  endfunction

  // Every row is {l, m, r}
  function automatic logic [8:0][7:0] cols3(input logic [7:0] l, input logic [7:0] m,
                                           input logic [7:0] r);
    logic [8:0][7:0] w;
    for (int i = 0; i < 3; i++) begin
      w[i*3]   = l;
      w[i*3+1] = m;
      w[i*3+2] = r;
    end
    return w;
  endfunction

  // Every column is {t, m, b} top to bottom
  function automatic logic [8:0][7:0] rows3(input logic [7:0] t, input logic [7:0] m,
                                           input logic [7:0] b);
    logic [8:0][7:0] w;
    for (int i = 0; i < 3; i++) begin
      w[i]   = t;
      w[3+i] = m;
      w[6+i] = b;
    end
    return w;
  endfunction

  // Drive one cycle, then check the output for the window driven three cycles earlier
  task automatic cycle(input logic en, input logic [1:0] mode, input logic [8:0][7:0] w,
                       input logic [7:0] exp_pix, input string tag);
    core_en = en;
    mode_in = mode;
    win     = w;
    @(posedge clk);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {en, exp_pix};
    chk({tag, " valid"}, int'(pix_valid_o), int'(hist[2].en));
    chk({tag, " busy"}, int'(busy_o), int'(hist[0].en | hist[1].en | hist[2].en));
    if (hist[2].en) begin
      chk({tag, " pix"}, int'(pix_o), int'(hist[2].pix));
      chk({tag, " col"}, int'(pix_col_o), int'(exp_col));
      chk({tag, " row"}, int'(pix_row_o), int'(exp_row));
      chk({tag, " line_done"}, int'(line_done_o), int'(exp_col == COLS - 1));
      chk({tag, " frame_done"}, int'(frame_done_o),
          int'(exp_col == COLS - 1 && exp_row == ROWS - 1));
      last_pix = hist[2].pix;
      if (exp_col == COLS - 1) begin
        exp_col = 0;
        exp_row = (exp_row == ROWS - 1) ? 0 : exp_row + 1;
      end else begin
        exp_col = exp_col + 1;
      end
    end else begin
      chk({tag, " pix hold"}, int'(pix_o), int'(last_pix));
      chk({tag, " line_done idle"}, int'(line_done_o), 0);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) cycle(1'b0, FMODE_PASS, mk(8'd0, 8'd0), 8'd0, "flush");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pix"}, int'(pix_o), 0);
    chk({tag, " valid"}, int'(pix_valid_o), 0);
    chk({tag, " col"}, int'(pix_col_o), 0);
    chk({tag, " row"}, int'(pix_row_o), 0);
    chk({tag, " line_done"}, int'(line_done_o), 0);
    chk({tag, " frame_done"}, int'(frame_done_o), 0);
    chk({tag, " busy"}, int'(busy_o), 0);
  endtask

  initial begin
    logic [8:0][7:0] diag;
    logic [5:0]      gap;
    logic [1:0]      tog_a [4];
    logic [1:0]      tog_b [4];

    diag    = mk(8'd0, 8'd0);
    diag[8] = 8'd50;
    vecs[0]  = '{FMODE_GAUSS,   mk(8'd255, 8'd255),         8'd255};
    vecs[1]  = '{FMODE_GAUSS,   mk(8'd16, 8'd0),            8'd4};
    vecs[2]  = '{FMODE_GAUSS,   mk(8'd1, 8'd1),             8'd1};
    vecs[3]  = '{FMODE_GAUSS,   mk(8'd100, 8'd0),           8'd25};
    vecs[4]  = '{FMODE_SOBEL,   cols3(8'd0, 8'd0, 8'd255),  8'd255};
    vecs[5]  = '{FMODE_SOBEL,   mk(8'd100, 8'd100),         8'd0};
    vecs[6]  = '{FMODE_SOBEL,   cols3(8'd10, 8'd15, 8'd20), 8'd40};
    vecs[7]  = '{FMODE_SOBEL,   cols3(8'd20, 8'd15, 8'd10), 8'd40};
    vecs[8]  = '{FMODE_SOBEL,   rows3(8'd0, 8'd0, 8'd50),   8'd200};
    vecs[9]  = '{FMODE_SOBEL,   diag,                       8'd100};
    vecs[10] = '{FMODE_LAPLACE, mk(8'd0, 8'd200),           8'd0};
    vecs[11] = '{FMODE_LAPLACE, mk(8'd100, 8'd0),           8'd255};
    vecs[12] = '{FMODE_LAPLACE, mk(8'd50, 8'd40),           8'd40};

    for (int i = 0; i < 3; i++) hist[i] = '0;
    rst_n   = 1'b0;
    core_en = 1'b0;
    mode_in = FMODE_PASS;
    win     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #3 rst_n = 1'b1;

    // PASS: 8 windows = one 4x2 frame, centre 10..17 with distracting neighbours
    for (int i = 0; i < 8; i++)
      cycle(1'b1, FMODE_PASS, mk(8'(10 + i), 8'd99), 8'(10 + i), "pass");
    flush();

    // Kernel table: each vector fills one full line, lines back to back
    for (int v = 0; v < 13; v++)
      for (int c = 0; c < int'(COLS); c++)
        cycle(1'b1, vecs[v].mode, vecs[v].w, vecs[v].exp, $sformatf("vec%0d", v));
    flush();

    // Enable gaps 1,0,1,1,0,1 reappear 3 cycles later; column moves on valid only
    gap = 6'b101101;
    for (int i = 0; i < 6; i++)
      cycle(gap[5-i], FMODE_PASS, mk(8'(40 + i), 8'd0), 8'(40 + i), "gap");
    flush();

    // Mode toggles after col 0 are ignored for the rest of the line
    tog_a = '{FMODE_GAUSS, FMODE_SOBEL, FMODE_LAPLACE, FMODE_PASS};
    tog_b = '{FMODE_LAPLACE, FMODE_PASS, FMODE_GAUSS, FMODE_SOBEL};
    for (int c = 0; c < 4; c++) cycle(1'b1, tog_a[c], mk(8'd100, 8'd0), 8'd25, "tog_gauss");
    for (int c = 0; c < 4; c++) cycle(1'b1, tog_b[c], mk(8'd100, 8'd0), 8'd255, "tog_lap");
    flush();

    // Reset mid-line with windows in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, FMODE_LAPLACE, mk(8'd5, 8'd0), 8'd20, "rst_pre");
    core_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    for (int i = 0; i < 3; i++) hist[i] = '0;
    exp_col  = 0;
    exp_row  = 0;
    last_pix = '0;
    #3 rst_n = 1'b1;
    cycle(1'b1, FMODE_PASS, mk(8'd30, 8'd0), 8'd30, "rst_post");
    for (int i = 1; i < 4; i++)
      cycle(1'b1, FMODE_LAPLACE, mk(8'(30 + i), 8'd0), 8'(30 + i), "rst_post");
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
